nand_bist_ctrl: RTL and testbench
=================================

Name: nand_bist_ctrl

Overview:
Self-test sequencer for bitwise_nand. It sits directly upstream of the nand, driving its i_op1/i_op2, and reads the nand's o_nand back. On start it sweeps every operand pair, waits a settle time, and compares the result against ~(op1 & op2). It reports pass/fail, an error count and the first failing vector.

Parameters:
WIDTH, 4, operand width; must match the nand under test.
SETTLE, 1, cycles each vector is held before sampling; must be >= 1.

Ports:
i_clk  input  1  clock; all state updates on rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  start request; level sampled on clock edge
o_op1  output  WIDTH  operand A to nand i_op1
o_op2  output  WIDTH  operand B to nand i_op2
i_nand  input  WIDTH  result from nand o_nand
o_busy  output  1  sweep in progress
o_done  output  1  sweep finished; held until restart or reset
o_pass  output  1  valid when o_done=1; 1 iff o_err_cnt==0
o_err_cnt  output  2*WIDTH+1  number of mismatching vectors
o_fail_op1  output  WIDTH  op1 of first mismatch
o_fail_op2  output  WIDTH  op2 of first mismatch
o_fail_res  output  WIDTH  i_nand value sampled at first mismatch

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. All outputs are 0. The first-error-captured flag is cleared.
- States: IDLE, APPLY, CHECK, DONE.
- IDLE or DONE with i_start=1:
  - go to APPLY.
  - op1 and op2 set to 0.
  - err_cnt, fail_* and the captured flag cleared.
  - o_done and o_pass set to 0; o_busy set to 1.
- APPLY: hold o_op1/o_op2 for exactly SETTLE cycles (settle counter), then go to CHECK.
- CHECK (one cycle): sample i_nand and compare with ~(o_op1 & o_op2), WIDTH bits.
  - On mismatch: err_cnt += 1. If no error has been captured yet, latch op1, op2 and i_nand into o_fail_* and set the captured flag.
  - If {op1,op2} is all ones: go to DONE.
  - Otherwise: increment the concatenated 2*WIDTH-bit counter {op1,op2} (op2 is the low half, so op2 wraps into op1) and go to APPLY.
- Vector order: (0,0), (0,1) … (0,F), (1,0) … (F,F).
- DONE:
  - o_busy=0, o_done=1, o_pass=(err_cnt==0).
  - Operands hold the last vector.
  - Results hold until the next i_start.
- Timing:
  - Each vector costs SETTLE+1 cycles.
  - o_done rises exactly 2^(2*WIDTH)*(SETTLE+1) edges after the edge that accepted i_start. WIDTH=4, SETTLE=1 gives 512.
- i_start while in APPLY/CHECK is ignored; there is no restart mid-sweep.
- err_cnt width holds the worst case (all vectors fail), so no overflow or saturation is needed.
- Reset asserted mid-sweep aborts immediately to the reset values above. Sweep resumes only on a new i_start.
- The nand is treated as combinational. i_nand is sampled only in CHECK, so values in APPLY are don't-care.

Optional Feature:
Macro NAND_BIST_STOP_ON_ERR_EN.
- Defined: the first mismatch in CHECK goes directly to DONE. o_err_cnt=1, o_pass=0, fail_* are latched, and the operands hold the failing vector.
- Undefined: full sweep always completes; every mismatch is counted.

Test Plan:
1. Correct nand model, WIDTH=4, SETTLE=1, pulse i_start -> o_busy for 512 cycles; o_done=1, o_pass=1, o_err_cnt=0; vector sequence (0,0)…(F,F) observed on o_op1/o_op2.
2. Nand model with bit0 stuck at 0 (macro undefined) -> o_done at 512 cycles; o_err_cnt=192, o_pass=0; o_fail_op1=0, o_fail_op2=0, o_fail_res=4'hE.
3. Same faulty model with NAND_BIST_STOP_ON_ERR_EN -> o_done 2 cycles after start; o_err_cnt=1; o_op1=o_op2=0; o_fail_res=4'hE.
4. Correct model, i_start pulsed again at cycle 100 of a sweep -> ignored; o_done still at 512 cycles. Then i_start in DONE -> counters clear, second sweep completes with o_err_cnt=0.
5. Assert i_rst_n=0 asynchronously at cycle 300 -> all outputs 0 immediately. After release with no i_start, stays IDLE.
6. SETTLE=3, correct model -> o_done exactly 1024 cycles after start; i_nand forced wrong during APPLY cycles only -> no errors counted.

Source files
------------

// File: rtl/nand_bist_ctrl.sv
// nand_bist_ctrl: self-test sequencer for bitwise_nand.
// Sweeps every {op1,op2} pair, holds each for SETTLE cycles, then checks the
// nand result against ~(op1 & op2). Reports pass/fail, an error count and the
// first failing vector.
// Optional build macro: NAND_BIST_STOP_ON_ERR_EN (stop the sweep at the first mismatch).
module nand_bist_ctrl #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_start,
    output logic [WIDTH-1:0]     o_op1,
    output logic [WIDTH-1:0]     o_op2,
    input  logic [WIDTH-1:0]     i_nand,
    output logic                 o_busy,
    output logic                 o_done,
    output logic                 o_pass,
    output logic [2*WIDTH:0]     o_err_cnt,
    output logic [WIDTH-1:0]     o_fail_op1,
    output logic [WIDTH-1:0]     o_fail_op2,
    output logic [WIDTH-1:0]     o_fail_res
);

    localparam int VW  = 2 * WIDTH;
    localparam int CW  = VW + 1;
    localparam int SCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [VW-1:0]      vec;
    logic [SCW-1:0]     settle_cnt;
    logic [CW-1:0]      err_cnt;
    logic               captured;
    logic [WIDTH-1:0]   fail_op1;
    logic [WIDTH-1:0]   fail_op2;
    logic [WIDTH-1:0]   fail_res;
    logic               settle_end;
    logic               mismatch;
    logic               last_vec;

    // op2 is the low half so it wraps into op1 when the vector counter increments
    assign o_op1      = vec[VW-1:WIDTH];
    assign o_op2      = vec[WIDTH-1:0];
    assign settle_end = (settle_cnt == SCW'(SETTLE - 1));
    assign mismatch   = (i_nand != ~(o_op1 & o_op2));
    assign last_vec   = &vec;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (settle_end) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
`ifdef NAND_BIST_STOP_ON_ERR_EN
                if (mismatch || last_vec) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                end
`else
                if (last_vec) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                end
`endif
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Vector counter, settle counter, error count and first-failure capture
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vec        <= '0;
            settle_cnt <= '0;
            err_cnt    <= '0;
            captured   <= 1'b0;
            fail_op1   <= '0;
            fail_op2   <= '0;
            fail_res   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        vec        <= '0;
                        settle_cnt <= '0;
                        err_cnt    <= '0;
                        captured   <= 1'b0;
                        fail_op1   <= '0;
                        fail_op2   <= '0;
                        fail_res   <= '0;
                    end
                end
                APPLY: begin
                    if (settle_end) begin
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!captured) begin
                            captured <= 1'b1;
                            fail_op1 <= o_op1;
                            fail_op2 <= o_op2;
                            fail_res <= i_nand;
                        end
                    end
                    // Operands only advance when another vector follows; DONE keeps the last one
                    if (state_nxt == APPLY) begin
                        vec <= vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (state == APPLY) || (state == CHECK);
    assign o_done     = (state == DONE);
    assign o_pass     = (state == DONE) && (err_cnt == '0);
    assign o_err_cnt  = err_cnt;
    assign o_fail_op1 = fail_op1;
    assign o_fail_op2 = fail_op2;
    assign o_fail_res = fail_res;

endmodule

// File: tb/tb_nand_bist_ctrl.sv
// Directed bench for nand_bist_ctrl: a WIDTH=4/SETTLE=1 instance driving a
// nand model with an optional bit0 stuck-at-0 fault, and a SETTLE=3 instance
// whose nand input is corrupted during APPLY cycles only.
module tb_nand_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       fault;
    logic [3:0] op1, op2, nand_in, fo1, fo2, fres;
    logic       busy, done, pass;
    logic [8:0] err;

    logic       start3;
    logic       corrupt;
    logic [3:0] op1_3, op2_3, nand3, fo1_3, fo2_3, fres_3;
    logic       busy3, done3, pass3;
    logic [8:0] err3;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Nand model: correct, or with bit0 stuck at 0
    assign nand_in = fault ? (~(op1 & op2) & 4'hE) : ~(op1 & op2);
    // Second model: deliberately wrong whenever corrupt is set
    assign nand3   = corrupt ? (op1_3 & op2_3) : ~(op1_3 & op2_3);

    nand_bist_ctrl #(.WIDTH(4), .SETTLE(1)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .o_op1(op1), .o_op2(op2), .i_nand(nand_in),
        .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_cnt(err),
        .o_fail_op1(fo1), .o_fail_op2(fo2), .o_fail_res(fres)
    );

    nand_bist_ctrl #(.WIDTH(4), .SETTLE(3)) u_dut3 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start3),
        .o_op1(op1_3), .o_op2(op2_3), .i_nand(nand3),
        .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_err_cnt(err3),
        .o_fail_op1(fo1_3), .o_fail_op2(fo2_3), .o_fail_res(fres_3)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Start a sweep on u_dut and count edges until o_done; optionally re-pulse start mid-sweep
    task automatic run_sweep(input int restart_at, output int edges);
        int seq_err;
        int exp_vec;
        seq_err = 0;
        edges   = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("clr_err",  32'(err), 32'd0);
        check("clr_fail", 32'({fo1, fo2, fres}), 32'd0);
        check("clr_flags", 32'({busy, done, pass}), 32'b100);
        check("clr_ops",  32'({op1, op2}), 32'd0);
        while (edges < 3000) begin
            start = (edges == restart_at);
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
            exp_vec = edges / 2;
            if ({op1, op2} !== exp_vec[7:0] || busy !== 1'b1) seq_err++;
        end
        start = 1'b0;
        check("seq", 32'(seq_err), 32'd0);
    endtask

    initial begin
        int edges;
        int e3;
        rst_n   = 1'b0;
        start   = 1'b0;
        start3  = 1'b0;
        fault   = 1'b0;
        corrupt = 1'b0;
        #1;
        // Reset state
        check("rst_flags", 32'({busy, done, pass}), 32'd0);
        check("rst_err",   32'(err), 32'd0);
        check("rst_vec",   32'({op1, op2, fo1, fo2, fres}), 32'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // 1: correct nand, full sweep
        run_sweep(-1, edges);
        check("t1_edges", 32'(edges), 32'd512);
        check("t1_pass",  32'({busy, done, pass}), 32'b011);
        check("t1_err",   32'(err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("t1_hold",  32'({done, op1, op2}), 32'h1FF);

        // 2/3: bit0 stuck at 0
        fault = 1'b1;
        run_sweep(-1, edges);
`ifdef NAND_BIST_STOP_ON_ERR_EN
        check("t3_edges", 32'(edges), 32'd2);
        check("t3_err",   32'(err), 32'd1);
        check("t3_ops",   32'({op1, op2}), 32'd0);
`else
        check("t2_edges", 32'(edges), 32'd512);
        check("t2_err",   32'(err), 32'd192);
        check("t2_ops",   32'({op1, op2}), 32'hFF);
`endif
        check("t2_pass",  32'({done, pass}), 32'b10);
        check("t2_fail",  32'({fo1, fo2, fres}), 32'h00E);
        fault = 1'b0;

        // 4: start mid-sweep ignored; restart from DONE clears results
        run_sweep(100, edges);
        check("t4_edges", 32'(edges), 32'd512);
        check("t4_err",   32'(err), 32'd0);
        check("t4_pass",  32'({done, pass}), 32'b11);
        check("t4_fail",  32'({fo1, fo2, fres}), 32'd0);

        // 5: asynchronous reset mid-sweep
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (300) @(posedge clk);
        #3;
        check("t5_pre_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_flags", 32'({busy, done, pass}), 32'd0);
        check("t5_err",   32'(err), 32'd0);
        check("t5_vec",   32'({op1, op2, fo1, fo2, fres}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("t5_idle",  32'({busy, done, op1, op2}), 32'd0);

        // 6: SETTLE=3, nand wrong only while operands settle
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3  = 1'b0;
        corrupt = 1'b1;
        e3      = 0;
        while (e3 < 5000) begin
            @(posedge clk);
            #1;
            e3++;
            corrupt = ((e3 % 4) != 3);
            if (done3) break;
        end
        corrupt = 1'b0;
        check("t6_edges", 32'(e3), 32'd1024);
        check("t6_err",   32'(err3), 32'd0);
        check("t6_pass",  32'({busy3, done3, pass3}), 32'b011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
